// File: rtl/cla_adder_arbiter.sv
// cla_adder_arbiter: round-robin arbiter that shares one carry-lookahead
// adder among NUM_REQ requesters. The winner's sum goes into a one-entry
// response slot that is tagged with the requester ID. The block also
// counts completed response handshakes.

// carry_lookahead_adder: generate/propagate adder. Every carry is expanded
// in flat sum-of-products form, so no carry ripples through a chain.
module carry_lookahead_adder #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_sum
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign gen  = i_a & i_b;
    assign prop = i_a ^ i_b;

    // Each carry c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... (carry-in is 0)
    always_comb begin
        logic carry_acc;
        logic term;
        carry     = '0;
        carry_acc = 1'b0;
        term      = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            carry_acc = gen[i];
            for (int j = 0; j < i; j++) begin
                term = gen[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & prop[k];
                end
                carry_acc = carry_acc | term;
            end
            carry[i+1] = carry_acc;
        end
    end

    assign o_sum = {carry[WIDTH], prop ^ carry[WIDTH-1:0]};

endmodule

module cla_adder_arbiter #(
    parameter int WIDTH   = 3,
    parameter int NUM_REQ = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_add1,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_add2,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [WIDTH:0]           o_rsp_result,
    output logic [$clog2(NUM_REQ)-1:0] o_rsp_id,
    output logic [15:0]              o_done_cnt
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W:0]   NUM_REQ_EXT = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX    = ID_W'(NUM_REQ - 1);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t       state;
    slot_state_t       state_next;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   winner_idx;
    logic              winner_found;
    logic              slot_free;
    logic              accept;
    logic              drain;
    logic [ID_W-1:0]   next_ptr;
    logic [WIDTH-1:0]  sel_add1;
    logic [WIDTH-1:0]  sel_add2;
    logic [WIDTH:0]    adder_sum;

    // Scan from r_ptr upward (modulo NUM_REQ). The loop runs from the farthest
    // offset to the nearest, so the nearest valid requester is written last and wins.
    always_comb begin
        logic [ID_W:0] cand_ext;
        winner_found = 1'b0;
        winner_idx   = '0;
        cand_ext     = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand_ext = {1'b0, r_ptr} + (ID_W+1)'(off);
            if (cand_ext >= NUM_REQ_EXT) begin
                cand_ext = cand_ext - NUM_REQ_EXT;
            end
            if (i_req_valid[ID_W'(cand_ext)]) begin
                winner_found = 1'b1;
                winner_idx   = ID_W'(cand_ext);
            end
        end
    end

    assign slot_free = !o_rsp_valid || i_rsp_ready;
    assign accept    = slot_free && winner_found && !i_rst;
    assign drain     = o_rsp_valid && i_rsp_ready;
    assign next_ptr  = (winner_idx == LAST_IDX) ? '0 : winner_idx + ID_W'(1);

    // The grant is one-hot on the winner. It is suppressed while the slot is busy or reset is high.
    always_comb begin
        o_req_ready = '0;
        if (accept) begin
            o_req_ready[winner_idx] = 1'b1;
        end
    end

    assign sel_add1 = i_req_add1[winner_idx*WIDTH +: WIDTH];
    assign sel_add2 = i_req_add2[winner_idx*WIDTH +: WIDTH];

    carry_lookahead_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a   (sel_add1),
        .i_b   (sel_add2),
        .o_sum (adder_sum)
    );

    // Response slot state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // An accept always fills the slot. A drain with no accept empties it.
    always_comb begin
        state_next = state;
        case (state)
            SLOT_EMPTY: if (accept) state_next = SLOT_FULL;
            SLOT_FULL:  if (drain && !accept) state_next = SLOT_EMPTY;
            default:    state_next = SLOT_EMPTY;
        endcase
    end

    assign o_rsp_valid = (state == SLOT_FULL);

    // Capture the sum and ID on accept, and advance the pointer past the winner
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_result <= '0;
            o_rsp_id     <= '0;
            r_ptr        <= '0;
        end else if (accept) begin
            o_rsp_result <= adder_sum;
            o_rsp_id     <= winner_idx;
            r_ptr        <= next_ptr;
        end
    end

    // Count completed response handshakes, saturating at all-ones
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_done_cnt <= '0;
        end else if (drain && (o_done_cnt != 16'hFFFF)) begin
            o_done_cnt <= o_done_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_cla_adder_arbiter.sv
// Directed testbench for cla_adder_arbiter. The defaults are WIDTH=3 and
// NUM_REQ=4. Inputs are driven 1 time unit after each rising edge, and
// outputs are sampled 1 time unit after that.
module tb_cla_adder_arbiter;

    localparam int WIDTH   = 3;
    localparam int NUM_REQ = 4;

    logic                     i_clk;
    logic                     i_rst;
    logic [NUM_REQ-1:0]       i_req_valid;
    logic [NUM_REQ-1:0]       o_req_ready;
    logic [NUM_REQ*WIDTH-1:0] i_req_add1;
    logic [NUM_REQ*WIDTH-1:0] i_req_add2;
    logic                     o_rsp_valid;
    logic                     i_rsp_ready;
    logic [WIDTH:0]           o_rsp_result;
    logic [1:0]               o_rsp_id;
    logic [15:0]              o_done_cnt;

    int total_cnt;
    int bad_cnt;

    cla_adder_arbiter #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_add1   (i_req_add1),
        .i_req_add2   (i_req_add2),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_result (o_rsp_result),
        .o_rsp_id     (o_rsp_id),
        .o_done_cnt   (o_done_cnt)
    );

    // Free-running clock with a 10-unit period
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Watchdog so that the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got !== want) begin
            bad_cnt++;
            $display("[TB] FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid,
                                 input logic [NUM_REQ*WIDTH-1:0] a1,
                                 input logic [NUM_REQ*WIDTH-1:0] a2,
                                 input logic rsp_rdy);
        i_req_valid = valid;
        i_req_add1  = a1;
        i_req_add2  = a2;
        i_rsp_ready = rsp_rdy;
    endtask

    // Advance to 1 unit after the next rising edge
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Lane operands for the contention tests. Sums: 4, 8, 10, 11.
    logic [NUM_REQ*WIDTH-1:0] lane_a1;
    logic [NUM_REQ*WIDTH-1:0] lane_a2;
    int exp_sum [NUM_REQ];

    initial begin
        logic [NUM_REQ*WIDTH-1:0] v1;
        logic [NUM_REQ*WIDTH-1:0] v2;
        logic [NUM_REQ-1:0]       one_hot;
        logic                     exp_valid;
        logic [31:0]              exp_result;
        logic [31:0]              exp_id;
        logic                     rr;
        logic                     free;
        logic                     accepted;
        logic [2:0]               op_a;
        logic [2:0]               op_b;
        int                       guard;

        total_cnt = 0;
        bad_cnt   = 0;
        lane_a1   = {3'd7, 3'd5, 3'd2, 3'd1};
        lane_a2   = {3'd4, 3'd5, 3'd6, 3'd3};
        exp_sum   = '{4, 8, 10, 11};

        // Reset held for two cycles with every requester valid
        i_rst = 1'b1;
        applyStimulus(4'hF, lane_a1, lane_a2, 1'b1);
        for (int c = 0; c < 2; c++) begin
            tick();
            checkOutput("rst_ready", o_req_ready, 0);
            checkOutput("rst_valid", o_rsp_valid, 0);
            checkOutput("rst_result", o_rsp_result, 0);
            checkOutput("rst_id", o_rsp_id, 0);
            checkOutput("rst_cnt", o_done_cnt, 0);
        end
        i_rst = 1'b0;
        #1;
        checkOutput("first_grant", o_req_ready, 4'b0001);
        // Withdraw the request before the edge. A dropped request gets no grant.
        applyStimulus(4'h0, lane_a1, lane_a2, 1'b1);
        tick();
        checkOutput("drop_valid", o_rsp_valid, 0);

        // Single request from requester 2: 7 + 7 = 14
        v1 = '0; v1[2*WIDTH +: WIDTH] = 3'd7;
        v2 = '0; v2[2*WIDTH +: WIDTH] = 3'd7;
        applyStimulus(4'b0100, v1, v2, 1'b1);
        #1;
        checkOutput("single_ready", o_req_ready, 4'b0100);
        tick();
        applyStimulus(4'b0000, v1, v2, 1'b1);
        #1;
        checkOutput("single_valid", o_rsp_valid, 1);
        checkOutput("single_result", o_rsp_result, 14);
        checkOutput("single_id", o_rsp_id, 2);
        checkOutput("single_cnt_pre", o_done_cnt, 0);
        tick();
        checkOutput("single_cnt", o_done_cnt, 1);
        checkOutput("single_empty", o_rsp_valid, 0);

        // Full contention after a reset pulse: grants go 0,1,2,3,0,1
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        applyStimulus(4'hF, lane_a1, lane_a2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            #1;
            one_hot = '0;
            one_hot[i % NUM_REQ] = 1'b1;
            checkOutput("cont_grant", o_req_ready, one_hot);
            if (i > 0) begin
                checkOutput("cont_valid", o_rsp_valid, 1);
                checkOutput("cont_result", o_rsp_result, exp_sum[(i-1) % NUM_REQ]);
                checkOutput("cont_id", o_rsp_id, (i-1) % NUM_REQ);
            end
            tick();
        end
        applyStimulus(4'h0, lane_a1, lane_a2, 1'b1);
        #1;
        checkOutput("cont_last_result", o_rsp_result, 8);
        checkOutput("cont_last_id", o_rsp_id, 1);
        tick();
        checkOutput("cont_cnt", o_done_cnt, 6);

        // Backpressure. The pointer is now at 2. One accept, then a 3-cycle stall.
        applyStimulus(4'hF, lane_a1, lane_a2, 1'b1);
        #1;
        checkOutput("bp_grant0", o_req_ready, 4'b0100);
        tick();
        i_rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("bp_ready_low", o_req_ready, 0);
            checkOutput("bp_hold_valid", o_rsp_valid, 1);
            checkOutput("bp_hold_result", o_rsp_result, 10);
            checkOutput("bp_hold_id", o_rsp_id, 2);
            tick();
        end
        i_rsp_ready = 1'b1;
        #1;
        checkOutput("bp_regrant", o_req_ready, 4'b1000);
        tick();
        applyStimulus(4'h0, lane_a1, lane_a2, 1'b1);
        #1;
        checkOutput("bp_next_valid", o_rsp_valid, 1);
        checkOutput("bp_next_result", o_rsp_result, 11);
        checkOutput("bp_next_id", o_rsp_id, 3);
        tick();
        checkOutput("bp_cnt", o_done_cnt, 8);

        // Exhaustive sweep with random backpressure, one requester at a time
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        exp_valid  = 1'b0;
        exp_result = 0;
        exp_id     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int pair = 0; pair < 64; pair++) begin
                op_a = 3'(pair >> 3);
                op_b = 3'(pair & 7);
                v1 = '0; v1[k*WIDTH +: WIDTH] = op_a;
                v2 = '0; v2[k*WIDTH +: WIDTH] = op_b;
                accepted = 1'b0;
                guard    = 0;
                while (!accepted) begin
                    rr = 1'($urandom_range(0, 1));
                    applyStimulus(4'(1 << k), v1, v2, rr);
                    #1;
                    free = !exp_valid || rr;
                    checkOutput("exh_ready", o_req_ready, free ? (1 << k) : 0);
                    checkOutput("exh_valid", o_rsp_valid, exp_valid);
                    if (exp_valid) begin
                        checkOutput("exh_result", o_rsp_result, exp_result);
                        checkOutput("exh_id", o_rsp_id, exp_id);
                    end
                    if (free) begin
                        exp_valid  = 1'b1;
                        exp_result = 32'(op_a) + 32'(op_b);
                        exp_id     = k;
                        accepted   = 1'b1;
                    end
                    tick();
                    guard++;
                    if (!accepted && guard > 64) begin
                        checkOutput("exh_timeout", 1, 0);
                        accepted = 1'b1;
                    end
                end
            end
        end
        applyStimulus(4'h0, '0, '0, 1'b1);
        #1;
        checkOutput("exh_tail_valid", o_rsp_valid, 1);
        checkOutput("exh_tail_result", o_rsp_result, exp_result);
        tick();
        checkOutput("exh_cnt", o_done_cnt, 256);
        checkOutput("exh_empty", o_rsp_valid, 0);

        // Reset while a response is stalled. The response must never be delivered.
        v1 = '0; v1[1*WIDTH +: WIDTH] = 3'd3;
        v2 = '0; v2[1*WIDTH +: WIDTH] = 3'd4;
        applyStimulus(4'b0010, v1, v2, 1'b0);
        #1;
        checkOutput("mid_grant", o_req_ready, 4'b0010);
        tick();
        applyStimulus(4'hF, lane_a1, lane_a2, 1'b0);
        #1;
        checkOutput("mid_valid", o_rsp_valid, 1);
        checkOutput("mid_result", o_rsp_result, 7);
        i_rst = 1'b1;
        #1;
        checkOutput("mid_rst_ready", o_req_ready, 0);
        tick();
        checkOutput("mid_rst_valid", o_rsp_valid, 0);
        checkOutput("mid_rst_cnt", o_done_cnt, 0);
        checkOutput("mid_rst_result", o_rsp_result, 0);
        i_rst = 1'b0;
        i_rsp_ready = 1'b1;
        #1;
        checkOutput("mid_ptr_zero", o_req_ready, 4'b0001);
        applyStimulus(4'h0, lane_a1, lane_a2, 1'b1);
        tick();
        checkOutput("mid_no_deliver", o_rsp_valid, 0);
        checkOutput("mid_cnt_hold", o_done_cnt, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
